// File: rtl/config_arb_pkg.sv
// Shared types and constants for the configuration write-port arbiter.
// Optional watchdog in the top level is enabled by defining CONFIG_ARB_WATCHDOG_EN.
package config_arb_pkg;

    localparam int unsigned CFG_DATA_WIDTH       = 32;
    localparam int unsigned CFG_DROP_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWITCH  = 2'd1,
        GRANTED = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_arb_prio_enc.sv
// Masked fixed-priority encoder: lowest eligible index wins, and reports whether
// that winner outranks the current owner.
module config_arb_prio_enc
    import config_arb_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned IDX_WIDTH    = idx_width(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [IDX_WIDTH-1:0]    owner,
    output logic [IDX_WIDTH-1:0]    winner,
    output logic                    valid,
    output logic                    higher
);

    logic [NUM_CHANNELS-1:0] eligible;

    always_comb begin
        eligible = req & ~mask;
        winner   = '0;
        valid    = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDX_WIDTH'(i);
                valid  = 1'b1;
            end
        end
        higher = valid && (winner < owner);
    end

endmodule

// File: rtl/config_port_arbiter.sv
// Fixed-priority, optionally preemptive arbiter merging config write sources.
// Define CONFIG_ARB_WATCHDOG_EN to add the stalled-owner watchdog and channel mask.
module config_port_arbiter
    import config_arb_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS     = 3,
    parameter int unsigned DATA_WIDTH       = CFG_DATA_WIDTH,
    parameter bit          PREEMPT          = 1'b1,
    parameter int unsigned DROP_COUNT_WIDTH = CFG_DROP_COUNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES   = 1048576
) (
    input  logic                               CLK,
    input  logic                               Reset,
    input  logic [NUM_CHANNELS-1:0]            ChActive,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ChWriteData,
    input  logic [NUM_CHANNELS-1:0]            ChWriteStrobe,
    output logic [DATA_WIDTH-1:0]              ConfigWriteData,
    output logic                               ConfigWriteStrobe,
    output logic                               FSMReset,
    output logic [NUM_CHANNELS-1:0]            Grant,
    output logic [DROP_COUNT_WIDTH-1:0]        DropCount,
    output logic                               TimeoutFlag
);

    localparam int unsigned IDX_WIDTH = idx_width(NUM_CHANNELS);

    arb_state_e state_q, state_d;
    logic [IDX_WIDTH-1:0] owner_q, owner_d;

    logic [DATA_WIDTH-1:0]       data_q;
    logic                        stb_q;
    logic [DROP_COUNT_WIDTH-1:0] drop_q;

    logic [IDX_WIDTH-1:0]    winner;
    logic                    win_valid;
    logic                    win_higher;
    logic [NUM_CHANNELS-1:0] mask;
    logic [NUM_CHANNELS-1:0] owner_onehot;
    logic [NUM_CHANNELS-1:0] kept;
    logic                    owner_active;
    logic                    owner_strobe;
    logic                    preempt_take;
    logic                    wd_expire;
    logic                    accept;
    logic                    drop_event;

    logic [DATA_WIDTH-1:0] ch_data [NUM_CHANNELS];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gen_split
        assign ch_data[g] = ChWriteData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign owner_active = ChActive[owner_q];
    assign owner_strobe = ChWriteStrobe[owner_q];
    assign owner_onehot = NUM_CHANNELS'(1) << owner_q;

    config_arb_prio_enc #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_prio_enc (
        .req    (ChActive),
        .mask   (mask),
        .owner  (owner_q),
        .winner (winner),
        .valid  (win_valid),
        .higher (win_higher)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        preempt_take = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = winner;
                    state_d = SWITCH;
                end
            end
            SWITCH: state_d = GRANTED;
            GRANTED: begin
                if (!owner_active) begin
                    // Hand over in one step when someone else is already waiting.
                    if (win_valid) begin
                        owner_d = winner;
                        state_d = SWITCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (PREEMPT && win_higher) begin
                    preempt_take = 1'b1;
                    owner_d      = winner;
                    state_d      = SWITCH;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Grant      = (state_q != IDLE) ? owner_onehot : '0;
        FSMReset   = (state_q == SWITCH);
        accept     = (state_q == GRANTED) && owner_strobe && !preempt_take;
        kept       = accept ? owner_onehot : '0;
        drop_event = |(ChWriteStrobe & ~kept);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            data_q <= '0;
            stb_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            stb_q <= accept;
            if (accept) begin
                data_q <= ch_data[owner_q];
            end
            if (drop_event && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_COUNT_WIDTH'(1);
            end
        end
    end

    assign ConfigWriteData   = data_q;
    assign ConfigWriteStrobe = stb_q;
    assign DropCount         = drop_q;

`ifdef CONFIG_ARB_WATCHDOG_EN
    localparam int unsigned WD_WIDTH = idx_width(TIMEOUT_CYCLES);

    logic [WD_WIDTH-1:0]     wd_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic                    timeout_q;
    logic                    timeout_take;

    assign wd_expire    = !owner_strobe && (wd_q == WD_WIDTH'(TIMEOUT_CYCLES - 1));
    assign timeout_take = (state_q == GRANTED) && (state_d == IDLE) && owner_active;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wd_q      <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_take;
            // A mask bit survives only while its channel keeps ChActive high.
            mask_q    <= (mask_q & ChActive) | (timeout_take ? owner_onehot : '0);
            if ((state_q == GRANTED) && !owner_strobe) begin
                wd_q <= wd_q + WD_WIDTH'(1);
            end else begin
                wd_q <= '0;
            end
        end
    end

    assign mask        = mask_q;
    assign TimeoutFlag = timeout_q;
`else
    assign wd_expire   = 1'b0;
    assign mask        = '0;
    assign TimeoutFlag = 1'b0;
`endif

endmodule

// File: tb/tb_config_port_arbiter.sv
// Bench for config_port_arbiter: a preemptive and a locking instance share stimulus,
// checked each cycle against a rule-level model plus literal spot checks.
module tb_config_port_arbiter;

    localparam int unsigned NC = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned TO = 16;
`ifdef CONFIG_ARB_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC-1:0]    ch_active = '0;
    logic [NC-1:0]    ch_strobe = '0;
    logic [NC*DW-1:0] ch_data   = '0;

    logic [DW-1:0] o_data  [2];
    logic          o_stb   [2];
    logic          o_fsmr  [2];
    logic          o_to    [2];
    logic [NC-1:0] o_grant [2];
    logic [CW-1:0] o_drop  [2];

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    config_port_arbiter #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .PREEMPT(1'b1),
        .DROP_COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) u_pre (
        .CLK(clk), .Reset(rst), .ChActive(ch_active), .ChWriteData(ch_data),
        .ChWriteStrobe(ch_strobe), .ConfigWriteData(o_data[0]),
        .ConfigWriteStrobe(o_stb[0]), .FSMReset(o_fsmr[0]), .Grant(o_grant[0]),
        .DropCount(o_drop[0]), .TimeoutFlag(o_to[0])
    );

    config_port_arbiter #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .PREEMPT(1'b0),
        .DROP_COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) u_lock (
        .CLK(clk), .Reset(rst), .ChActive(ch_active), .ChWriteData(ch_data),
        .ChWriteStrobe(ch_strobe), .ConfigWriteData(o_data[1]),
        .ConfigWriteStrobe(o_stb[1]), .FSMReset(o_fsmr[1]), .Grant(o_grant[1]),
        .DropCount(o_drop[1]), .TimeoutFlag(o_to[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: who owns the bus (-1 none), whether this is the acquisition cycle,
    // and the cycles since the owner last wrote. Index 0 = preemptive, 1 = locking.
    int            m_own  [2] = '{-1, -1};
    bit            m_sw   [2];
    logic [DW-1:0] m_data [2];
    bit            m_stb  [2];
    int            m_drop [2];
    bit            m_to   [2];
    int            m_idle [2];
    logic [NC-1:0] m_mask [2];

    int lowest, o;
    bit take, lost, fire;
    logic [NC-1:0] others, nm;

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                m_own[p] = -1; m_sw[p] = 0; m_data[p] = '0; m_stb[p] = 0;
                m_drop[p] = 0; m_to[p] = 0; m_idle[p] = 0; m_mask[p] = '0;
            end else begin
                lowest = -1;
                for (int i = NC - 1; i >= 0; i--)
                    if (ch_active[i] && !m_mask[p][i]) lowest = i;
                o = m_own[p]; take = 0; lost = 0; fire = 0;
                nm = m_mask[p] & ch_active;
                others = (o >= 0) ? (ch_strobe & ~(3'b001 << o)) : ch_strobe;
                if (o < 0) begin
                    lost = |ch_strobe;
                    if (lowest >= 0) begin m_own[p] = lowest; m_sw[p] = 1; end
                end else if (m_sw[p]) begin
                    lost = |ch_strobe; m_sw[p] = 0; m_idle[p] = 0;
                end else if (!ch_active[o]) begin
                    take = ch_strobe[o]; lost = |others;
                    m_own[p] = lowest; m_sw[p] = (lowest >= 0);
                end else if (p == 0 && lowest >= 0 && lowest < o) begin
                    lost = |ch_strobe; m_own[p] = lowest; m_sw[p] = 1;
                end else if (WD_EN && !ch_strobe[o] && m_idle[p] == TO - 1) begin
                    lost = |others; fire = 1; nm[o] = 1'b1; m_own[p] = -1;
                end else begin
                    take = ch_strobe[o]; lost = |others;
                    m_idle[p] = ch_strobe[o] ? 0 : m_idle[p] + 1;
                end
                if (take) m_data[p] = ch_data[o*DW +: DW];
                m_stb[p] = take; m_to[p] = fire; m_mask[p] = nm;
                if (lost && m_drop[p] < (1 << CW) - 1) m_drop[p]++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("u%0d data", p), 64'(o_data[p]), 64'(m_data[p]));
                check($sformatf("u%0d strobe", p), 64'(o_stb[p]), 64'(m_stb[p]));
                check($sformatf("u%0d fsmreset", p), 64'(o_fsmr[p]), 64'(m_sw[p]));
                check($sformatf("u%0d grant", p), 64'(o_grant[p]),
                      (m_own[p] < 0) ? 64'd0 : 64'(3'b001 << m_own[p]));
                check($sformatf("u%0d dropcount", p), 64'(o_drop[p]), 64'(m_drop[p]));
                check($sformatf("u%0d timeout", p), 64'(o_to[p]), 64'(m_to[p]));
            end
        end
    end

    task automatic drive(input logic [NC-1:0] act, input logic [NC-1:0] stb,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2);
        ch_active = act;
        ch_strobe = stb;
        ch_data   = {w2, w1, w0};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 3'b000, '0, '0, '0);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            check("reset data", 64'(o_data[p]), 64'd0);
            check("reset grant", 64'(o_grant[p]), 64'd0);
            check("reset fsmreset", 64'(o_fsmr[p]), 64'd0);
            check("reset dropcount", 64'(o_drop[p]), 64'd0);
        end
        cmp_en = 1'b1;
        rst = 1'b0;

        // Single channel: ch2 alone streams three words.
        do_reset();
        drive(3'b100, 3'b000, '0, '0, '0);
        check("single fsmreset k+1", 64'(o_fsmr[0]), 64'd1);
        drive(3'b100, 3'b000, '0, '0, '0);
        for (int i = 1; i <= 3; i++)
            drive(3'b100, 3'b100, 32'h1111_0000, 32'h2222_0000, 32'hA5A5_0000 + i);
        for (int p = 0; p < 2; p++) begin
            check("single last word", 64'(o_data[p]), 64'hA5A5_0003);
            check("single strobe", 64'(o_stb[p]), 64'd1);
            check("single drops", 64'(o_drop[p]), 64'd0);
        end
        drive(3'b000, 3'b000, '0, '0, '0);
        check("release grant", 64'(o_grant[0]), 64'd0);

        // Preemption vs lock: ch0 rises while ch2 strobes.
        do_reset();
        drive(3'b100, 3'b000, '0, '0, '0);
        drive(3'b100, 3'b000, '0, '0, '0);
        drive(3'b100, 3'b100, '0, '0, 32'h0000_0B01);
        drive(3'b101, 3'b100, 32'hEEEE_0000, '0, 32'h0000_0B02);
        check("pre grant", 64'(o_grant[0]), 64'b001);
        check("pre fsmreset", 64'(o_fsmr[0]), 64'd1);
        check("pre drop", 64'(o_drop[0]), 64'd1);
        check("lock grant", 64'(o_grant[1]), 64'b100);
        check("lock data", 64'(o_data[1]), 64'h0000_0B02);
        drive(3'b101, 3'b000, '0, '0, '0);
        drive(3'b101, 3'b001, 32'hC000_0001, '0, 32'h0BAD_0001);
        drive(3'b101, 3'b001, 32'hC000_0002, '0, 32'h0BAD_0002);
        check("pre ch0 data", 64'(o_data[0]), 64'hC000_0002);
        check("pre drop held", 64'(o_drop[0]), 64'd1);
        check("lock drops", 64'(o_drop[1]), 64'd2);
        check("lock data held", 64'(o_data[1]), 64'h0000_0B02);
        drive(3'b001, 3'b000, '0, '0, '0);
        check("lock handover fsmreset", 64'(o_fsmr[1]), 64'd1);
        check("lock handover grant", 64'(o_grant[1]), 64'b001);
        drive(3'b001, 3'b000, '0, '0, '0);
        drive(3'b001, 3'b001, 32'hC000_0003, '0, '0);
        check("lock ch0 data", 64'(o_data[1]), 64'hC000_0003);

        // Drop counter saturation.
        do_reset();
        drive(3'b100, 3'b000, '0, '0, '0);
        drive(3'b100, 3'b000, '0, '0, '0);
        for (int i = 0; i < 20; i++) drive(3'b100, 3'b011, 32'h1, 32'h2, 32'h3);
        drive(3'b100, 3'b000, '0, '0, '0);
        for (int p = 0; p < 2; p++) check("saturated", 64'(o_drop[p]), 64'hF);

        // Stalled owner ch1 with ch2 waiting.
        do_reset();
        drive(3'b010, 3'b000, '0, '0, '0);
        drive(3'b010, 3'b000, '0, '0, '0);
        for (int i = 0; i < 16; i++) drive(3'b110, 3'b000, '0, '0, '0);
        if (WD_EN) begin
            check("wd flag", 64'(o_to[0]), 64'd1);
            check("wd idle grant", 64'(o_grant[1]), 64'd0);
        end else begin
            check("no wd flag", 64'(o_to[0]), 64'd0);
            check("no wd held", 64'(o_grant[0]), 64'b010);
        end
        drive(3'b110, 3'b000, '0, '0, '0);
        if (WD_EN) begin
            check("wd ch2 grant", 64'(o_grant[0]), 64'b100);
            check("wd flag pulse", 64'(o_to[0]), 64'd0);
        end
        drive(3'b110, 3'b000, '0, '0, '0);
        drive(3'b100, 3'b000, '0, '0, '0);
        drive(3'b110, 3'b000, '0, '0, '0);
        if (WD_EN) begin
            check("wd ch1 eligible", 64'(o_grant[0]), 64'b010);
            check("wd lock keeps ch2", 64'(o_grant[1]), 64'b100);
        end

        // Reset in the middle of a transfer.
        do_reset();
        drive(3'b001, 3'b000, '0, '0, '0);
        drive(3'b001, 3'b000, '0, '0, '0);
        drive(3'b001, 3'b001, 32'hD000_0001, '0, '0);
        rst = 1'b1;
        drive(3'b001, 3'b001, 32'hD000_0002, '0, '0);
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            check("midreset data", 64'(o_data[p]), 64'd0);
            check("midreset strobe", 64'(o_stb[p]), 64'd0);
            check("midreset grant", 64'(o_grant[p]), 64'd0);
            check("midreset drop", 64'(o_drop[p]), 64'd0);
        end
        drive(3'b001, 3'b000, '0, '0, '0);
        check("regrant fsmreset", 64'(o_fsmr[0]), 64'd1);
        drive(3'b001, 3'b000, '0, '0, '0);
        drive(3'b001, 3'b001, 32'hD000_0003, '0, '0);
        check("regrant data", 64'(o_data[0]), 64'hD000_0003);

        drive(3'b000, 3'b000, '0, '0, '0);
        drive(3'b000, 3'b000, '0, '0, '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
